// File: rtl/rpi_board_rx.sv
// rtl/rpi_board_rx.sv - serial Connect-4 board receiver from the Raspberry Pi link
// Optional feature macro: RPI_RX_CHECKSUM_EN (trailer nibble must equal XOR of board nibbles)
module rpi_board_rx #(
  parameter int FRAME_BITS = 88,
  parameter int BOARD_BITS = 84
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rpi_sclk,
  input  logic                  rpi_sdata,
  input  logic                  rpi_frame,
  output logic [BOARD_BITS-1:0] board,
  output logic                  board_valid,
  output logic                  frame_error,
  output logic                  rx_busy
);

  localparam int CELLS = BOARD_BITS / 2;
  localparam int NIBBLES = BOARD_BITS / 4;
  localparam logic [6:0] FULL = 7'(FRAME_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state, state_next;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic sdata_s1, sdata_s2;
  logic frame_s1, frame_s2, frame_s3;
  logic [1:0] fill;
  logic armed;
  logic sclk_rise, frame_rise, frame_fall;

  logic [FRAME_BITS-1:0] shreg;
  logic [6:0] count;
  logic overrun;
  logic frame_ok;

  // Two-flop synchronisers plus a third stage on sclk and frame for edge detection.
  // After reset the frame line is only armed once it has been seen low with real
  // samples, so the tail of a frame interrupted by reset is never mistaken for a start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_s1  <= 1'b0;
      sclk_s2  <= 1'b0;
      sclk_s3  <= 1'b0;
      sdata_s1 <= 1'b0;
      sdata_s2 <= 1'b0;
      frame_s1 <= 1'b0;
      frame_s2 <= 1'b0;
      frame_s3 <= 1'b0;
      fill     <= 2'd0;
      armed    <= 1'b0;
    end else begin
      sclk_s1  <= rpi_sclk;
      sclk_s2  <= sclk_s1;
      sclk_s3  <= sclk_s2;
      sdata_s1 <= rpi_sdata;
      sdata_s2 <= sdata_s1;
      frame_s1 <= rpi_frame;
      frame_s2 <= frame_s1;
      frame_s3 <= frame_s2;
      if (fill != 2'd2) fill <= fill + 2'd1;
      if (fill == 2'd2 && !frame_s2) armed <= 1'b1;
    end
  end

  assign sclk_rise  = sclk_s2 & ~sclk_s3;
  assign frame_rise = frame_s2 & ~frame_s3 & armed;
  assign frame_fall = ~frame_s2 & frame_s3;

  // Frame validation: exact length, no illegal 2'b11 cell, optional trailer checksum.
  always_comb begin
    logic cells_ok;
    logic cks_ok;
    logic len_ok;
`ifdef RPI_RX_CHECKSUM_EN
    logic [3:0] cks;
`endif
    cells_ok = 1'b1;
    for (int c = 0; c < CELLS; c++) begin
      if (shreg[2*c +: 2] == 2'b11) cells_ok = 1'b0;
    end
    len_ok = (count == FULL) && !overrun;
`ifdef RPI_RX_CHECKSUM_EN
    cks = 4'd0;
    for (int n = 0; n < NIBBLES; n++) begin
      cks = cks ^ shreg[4*n +: 4];
    end
    cks_ok = (cks == shreg[FRAME_BITS-1 -: 4]);
`else
    cks_ok = 1'b1;
`endif
    frame_ok = cells_ok && len_ok && cks_ok;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; a frame start during CHECK is deliberately ignored.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_rise) state_next = RECV;
      RECV:    if (frame_fall) state_next = CHECK;
      CHECK:   state_next = frame_ok ? HOLD : IDLE;
      HOLD:    if (frame_rise) state_next = RECV;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded from state; board_valid drops the cycle RECV is entered.
  always_comb begin
    board_valid = 1'b0;
    rx_busy     = 1'b0;
    case (state)
      RECV:    rx_busy = 1'b1;
      CHECK:   rx_busy = 1'b1;
      HOLD:    board_valid = 1'b1;
      default: ;
    endcase
  end

  // Shift register, saturating bit counter, sticky error and board capture.
  // Bits arrive LSB first and enter at the top, so after exactly FRAME_BITS shifts
  // frame bit k sits at shreg[k]. Bits beyond FRAME_BITS only flag an overrun.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg       <= '0;
      count       <= 7'd0;
      overrun     <= 1'b0;
      frame_error <= 1'b0;
      board       <= '0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (frame_rise) begin
            shreg       <= '0;
            count       <= 7'd0;
            overrun     <= 1'b0;
            frame_error <= 1'b0;
          end
        end
        RECV: begin
          if (sclk_rise) begin
            if (count == FULL) begin
              overrun <= 1'b1;
            end else begin
              shreg <= {sdata_s2, shreg[FRAME_BITS-1:1]};
              count <= count + 7'd1;
            end
          end
        end
        CHECK: begin
          if (frame_ok) board <= shreg[BOARD_BITS-1:0];
          else          frame_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rpi_board_rx.sv
// tb/tb_rpi_board_rx.sv - randomized self-checking bench for rpi_board_rx
module tb_rpi_board_rx;

  logic        clk;
  logic        reset;
  logic        rpi_sclk;
  logic        rpi_sdata;
  logic        rpi_frame;
  logic [83:0] board;
  logic        board_valid;
  logic        frame_error;
  logic        rx_busy;

  int tests_run;
  int tests_failed;

  logic [83:0] exp_board;
  logic        mid_valid;
  logic        mid_busy;

  rpi_board_rx #(.FRAME_BITS(88), .BOARD_BITS(84)) dut (
    .clk         (clk),
    .reset       (reset),
    .rpi_sclk    (rpi_sclk),
    .rpi_sdata   (rpi_sdata),
    .rpi_frame   (rpi_frame),
    .board       (board),
    .board_valid (board_valid),
    .frame_error (frame_error),
    .rx_busy     (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: XOR of the 21 board nibbles.
  function automatic logic [3:0] model_cks(input logic [83:0] b);
    logic [83:0] t;
    logic [3:0] x;
    x = 4'd0;
    t = b;
    for (int i = 0; i < 21; i++) begin
      x = x ^ 4'(t % 16);
      t = t / 16;
    end
    return x;
  endfunction

  // Reference acceptance rule for a frame of n bits.
  function automatic bit model_accept(input logic [95:0] f, input int n);
    logic [95:0] t;
    if (n != 88) return 1'b0;
    t = f;
    for (int c = 0; c < 42; c++) begin
      if ((t % 4) == 3) return 1'b0;
      t = t / 4;
    end
`ifdef RPI_RX_CHECKSUM_EN
    if (model_cks(f[83:0]) != f[87:84]) return 1'b0;
`endif
    return 1'b1;
  endfunction

  function automatic logic [83:0] rand_board();
    logic [83:0] b;
    for (int c = 0; c < 42; c++) b[2*c +: 2] = 2'($urandom_range(0, 2));
    return b;
  endfunction

  function automatic logic [95:0] build_frame(input logic [83:0] b);
    logic [95:0] f;
    f[83:0]  = b;
    f[87:84] = model_cks(b);
    f[95:88] = 8'($urandom);
    return f;
  endfunction

  task automatic start_frame();
    rpi_frame = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [95:0] f, input int lo, input int hi);
    for (int k = lo; k < hi; k++) begin
      rpi_sdata = f[k];
      repeat (4) @(negedge clk);
      rpi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      rpi_sclk = 1'b0;
    end
  endtask

  // Sends bits, drops frame, samples 3 cycles later (CHECK) and again 4 cycles later.
  task automatic send_body(input logic [95:0] f, input int n);
    send_bits(f, 0, n);
    repeat (4) @(negedge clk);
    rpi_frame = 1'b0;
    repeat (3) @(negedge clk);
    mid_valid = board_valid;
    mid_busy  = rx_busy;
    @(negedge clk);
    if (model_accept(f, n)) exp_board = f[83:0];
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rpi_sclk = 1'b0;
    rpi_sdata = 1'b0;
    rpi_frame = 1'b0;
    exp_board = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (board !== 84'd0) begin tests_failed++; $display("FAIL reset_board: got %h want 0", board); end
    tests_run++;
    if (board_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", board_valid); end
    tests_run++;
    if (frame_error !== 1'b0) begin tests_failed++; $display("FAIL reset_error: got %b want 0", frame_error); end
    tests_run++;
    if (rx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
  endtask

  task automatic test_good_frame();
    logic [83:0] b;
    b = '0;
    b[7:6]   = 2'b01;
    b[77:76] = 2'b10;
    start_frame();
    send_body(build_frame(b), 88);
    tests_run++;
    if (mid_valid !== 1'b0 || mid_busy !== 1'b1) begin
      tests_failed++; $display("FAIL good_latency: valid=%b busy=%b want valid=0 busy=1", mid_valid, mid_busy);
    end
    tests_run++;
    if (board_valid !== 1'b1) begin tests_failed++; $display("FAIL good_valid: got %b want 1", board_valid); end
    tests_run++;
    if (board !== 84'h020000000000000000040) begin
      tests_failed++; $display("FAIL good_board: got %h want 020000000000000000040", board);
    end
    tests_run++;
    if (frame_error !== 1'b0 || rx_busy !== 1'b0) begin
      tests_failed++; $display("FAIL good_flags: err=%b busy=%b want 0 0", frame_error, rx_busy);
    end
  endtask

  task automatic test_short_frame();
    start_frame();
    send_body(build_frame(rand_board()), 87);
    tests_run++;
    if (frame_error !== 1'b1 || board_valid !== 1'b0) begin
      tests_failed++; $display("FAIL short_flags: err=%b valid=%b want 1 0", frame_error, board_valid);
    end
    tests_run++;
    if (board !== exp_board) begin tests_failed++; $display("FAIL short_board: got %h want %h", board, exp_board); end
  endtask

  task automatic test_overrun();
    start_frame();
    send_body(build_frame(rand_board()), 90);
    tests_run++;
    if (frame_error !== 1'b1 || board_valid !== 1'b0) begin
      tests_failed++; $display("FAIL overrun_flags: err=%b valid=%b want 1 0", frame_error, board_valid);
    end
    tests_run++;
    if (board !== exp_board) begin tests_failed++; $display("FAIL overrun_board: got %h want %h", board, exp_board); end
  endtask

  task automatic test_bad_cell();
    logic [83:0] b;
    b = rand_board();
    b[1:0] = 2'b11;
    start_frame();
    send_body(build_frame(b), 88);
    tests_run++;
    if (frame_error !== 1'b1 || board_valid !== 1'b0) begin
      tests_failed++; $display("FAIL badcell_flags: err=%b valid=%b want 1 0", frame_error, board_valid);
    end
    tests_run++;
    if (board !== exp_board) begin tests_failed++; $display("FAIL badcell_board: got %h want %h", board, exp_board); end
  endtask

  task automatic test_checksum();
    logic [95:0] f;
    bit acc;
    f = build_frame(rand_board());
    f[84] = ~f[84];
    acc = model_accept(f, 88);
    start_frame();
    send_body(f, 88);
    tests_run++;
    if (board_valid !== acc || frame_error !== !acc) begin
      tests_failed++; $display("FAIL cks_flags: valid=%b err=%b want valid=%b", board_valid, frame_error, acc);
    end
    tests_run++;
    if (board !== exp_board) begin tests_failed++; $display("FAIL cks_board: got %h want %h", board, exp_board); end
  endtask

  task automatic test_back_to_back();
    logic [95:0] f;
    f = build_frame(rand_board());
    start_frame();
    send_body(f, 88);
    tests_run++;
    if (board_valid !== 1'b1 || board !== exp_board) begin
      tests_failed++; $display("FAIL b2b_first: valid=%b board=%h want 1 %h", board_valid, board, exp_board);
    end
    f = build_frame(rand_board());
    rpi_frame = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (board_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_hold: got %b want 1", board_valid); end
    @(negedge clk);
    tests_run++;
    if (board_valid !== 1'b0 || rx_busy !== 1'b1) begin
      tests_failed++; $display("FAIL b2b_drop: valid=%b busy=%b want 0 1", board_valid, rx_busy);
    end
    @(negedge clk);
    send_body(f, 88);
    tests_run++;
    if (board_valid !== 1'b1 || board !== exp_board || frame_error !== 1'b0) begin
      tests_failed++; $display("FAIL b2b_second: valid=%b board=%h err=%b want 1 %h 0", board_valid, board, frame_error, exp_board);
    end
  endtask

  task automatic test_random();
    logic [95:0] f;
    logic [83:0] b;
    int n;
    int kind;
    bit acc;
    for (int i = 0; i < 12; i++) begin
      kind = int'($urandom_range(0, 4));
      b = rand_board();
      n = 88;
      if (kind == 3) b[2*$urandom_range(0, 41) +: 2] = 2'b11;
      f = build_frame(b);
      if (kind == 1) n = 88 - int'($urandom_range(1, 3));
      if (kind == 2) n = 88 + int'($urandom_range(1, 3));
      if (kind == 4) f[84 + $urandom_range(0, 3)] ^= 1'b1;
      acc = model_accept(f, n);
      start_frame();
      send_body(f, n);
      tests_run++;
      if (board_valid !== acc || frame_error !== !acc || board !== exp_board || mid_busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL random_%0d: valid=%b err=%b busy=%b board=%h want valid=%b board=%h", i, board_valid, frame_error, mid_busy, board, acc, exp_board);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [95:0] f;
    f = build_frame(rand_board());
    start_frame();
    send_bits(f, 0, 40);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    exp_board = '0;
    tests_run++;
    if (board !== 84'd0 || board_valid !== 1'b0 || frame_error !== 1'b0 || rx_busy !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_during: board=%h valid=%b err=%b busy=%b want all 0", board, board_valid, frame_error, rx_busy);
    end
    reset = 1'b1;
    send_bits(f, 40, 88);
    repeat (4) @(negedge clk);
    rpi_frame = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++;
    if (board !== 84'd0 || board_valid !== 1'b0 || frame_error !== 1'b0 || rx_busy !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_tail: board=%h valid=%b err=%b busy=%b want all 0", board, board_valid, frame_error, rx_busy);
    end
    f = build_frame(rand_board());
    start_frame();
    send_body(f, 88);
    tests_run++;
    if (board_valid !== 1'b1 || board !== f[83:0] || frame_error !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_next: valid=%b board=%h err=%b want 1 %h 0", board_valid, board, frame_error, f[83:0]);
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_good_frame();
    test_short_frame();
    test_overrun();
    test_bad_cell();
    test_checksum();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rpi_board_rx.md
# rpi_board_rx

Serial receiver that sits directly upstream of the board evaluator. It captures one Connect-4 position sent by the Raspberry Pi as an 88-bit frame over a three-wire link (serial clock, data, frame strobe). It validates the frame, then presents the 84-bit board with a level-valid flag that drives the evaluator's `board` and `rpi_data_stable` inputs.

## Interface
Parameters:
- `FRAME_BITS`, 88: bits per frame, 84 board bits plus 4 trailer bits.
- `BOARD_BITS`, 84: board width, 6 rows × 7 cols × 2 bits.

Ports:
- `clk`  in  1  FPGA clock.
- `reset`  in  1  synchronous, active-low.
- `rpi_sclk`  in  1  Pi serial clock; asynchronous to `clk`.
- `rpi_sdata`  in  1  Pi serial data; asynchronous.
- `rpi_frame`  in  1  frame strobe; high for the whole frame; asynchronous.
- `board`  out  84  last accepted board. Cell c = row·7+col occupies bits [2c+1:2c]. Codes: 0 empty, 1 AI, 2 human.
- `board_valid`  out  1  high while `board` holds an accepted frame. Feeds `rpi_data_stable`.
- `frame_error`  out  1  sticky; the last frame was rejected.
- `rx_busy`  out  1  high while a frame is being received.

## Operation
- **Synchronisers.** `rpi_sclk`, `rpi_sdata` and `rpi_frame` each pass through a 2-FF synchroniser.
- **Edge detect.** A third `rpi_sclk` stage gives rising-edge detect: stage2 & ~stage3. All logic uses only the synchronised signals.
- **Bit order.** Bits are sent LSB first. Frame bit k is shifted in as the k-th sample.
  - Bits 0–83 are the board.
  - Bits 84–87 are the checksum nibble.
- **Bit counter.** 7 bits wide, saturating at 88. Bits received after the 88th are not stored, but they make the length invalid.

State machine:
- **IDLE.**
  - On synchronised frame rising: clear the bit counter, the shift register and `frame_error`; drop `board_valid`; go to RECV.
- **RECV.**
  - On each sclk rising edge: shift in sdata and increment the counter.
  - On synchronised frame falling: go to CHECK.
- **CHECK (1 cycle).** The frame is accepted only if all of these hold:
  - count is exactly 88 and no overrun occurred;
  - no cell equals 2'b11;
  - the checksum passes (see Configuration).
  - Accept: load `board`, go to HOLD.
  - Reject: set `frame_error`, leave `board` unchanged, go to IDLE.
- **HOLD.**
  - `board_valid` = 1.
  - On the next frame rising edge: drop `board_valid`, clear `frame_error`, go to RECV.

Outputs:
- `rx_busy` = 1 in RECV and CHECK.
- `board` changes only on the CHECK→HOLD transition, so it is stable whenever `board_valid` = 1.

## Timing
- **Reset values.** `board` = 0, `board_valid` = 0, `frame_error` = 0, `rx_busy` = 0, state IDLE, synchroniser flops 0.
- **Link timing.** Each `rpi_sclk` high and low phase must be ≥ 3 `clk` cycles. `rpi_sdata` must be stable across the sclk rising edge.
- **Frame-start latency.** A raw frame rising edge reaches RECV 3 cycles later. `board_valid` falls in the same cycle.
- **Frame-end latency.** A raw frame falling edge leads to `board_valid` (or `frame_error`) rising 4 cycles later: 2 sync + edge + CHECK.
- **Simultaneous events.** If an sclk edge and a frame falling edge are detected in the same cycle, the bit is shifted first, then CHECK.
- **Reset mid-frame.** Everything returns to reset values. The remaining bits of the interrupted frame are ignored until a new frame rising edge.
- **Frame rising in CHECK.** It is ignored, so the sender must hold frame low for ≥ 4 cycles between frames.

## Configuration
- **`RPI_RX_CHECKSUM_EN` defined.** Trailer bits 84–87 must equal the XOR of the 21 board nibbles. A mismatch rejects the frame.
- **`RPI_RX_CHECKSUM_EN` undefined.** The trailer is received and counted but ignored. Only the length and 2'b11 cell checks apply.

## Test plan
- Reset mid-RECV (after 40 bits) → all outputs 0, state IDLE. A following good frame is accepted normally.
- Good frame: board with cell 3 = AI (bits [7:6]=01), cell 38 = human, rest empty, correct checksum → `board` = 84'h…, `board_valid` rises 4 cycles after frame falls, `frame_error` = 0.
- Short frame: 87 bits → `frame_error` = 1, `board_valid` = 0, `board` keeps its previous value.
- Overrun: 90 bits → rejected, `frame_error` = 1.
- Cell code 2'b11 at cell 0 → rejected.
- With `RPI_RX_CHECKSUM_EN`: trailer off by one bit → rejected. Without the macro, the same frame is accepted.
- Back-to-back frames with 4-cycle frame-low gap → `board_valid` drops at second frame start, reasserts with the new board. No state is lost.
